// File: rtl/wav_recorder_pkg.sv
// Shared sound constants and FSM encoding for the PWM player/recorder pair.
package wav_recorder_pkg;

    localparam int unsigned FRAME_TICKS      = 256;
    localparam int unsigned SAMPLE_W         = 8;
    localparam int unsigned DEFAULT_PRESCALE = 25;
    localparam int unsigned TICK_W           = $clog2(FRAME_TICKS);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StDone    = 2'd2
    } snd_state_e;

    // Clamp a frame sum to the sample range; 256 only arises from a constant-high source.
    function automatic logic [SAMPLE_W-1:0] sat_sample(input logic [SAMPLE_W:0] acc);
        return acc[SAMPLE_W] ? {SAMPLE_W{1'b1}} : acc[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/wav_recorder_pwm_tick_gen.sv
// Prescaler plus frame tick counter: one tick every PRESCALE clocks, 256 ticks per frame.
module wav_recorder_pwm_tick_gen
    import wav_recorder_pkg::*;
#(
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tick,
    output logic o_frame_end
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [PW-1:0]     r_presc;
    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_tick;

    assign w_tick      = i_en && (r_presc == PMAX);
    assign o_tick      = w_tick;
    assign o_frame_end = w_tick && (r_tick_cnt == '1);

    // Prescaler wraps at PRESCALE-1; tick counter advances (and wraps) on every tick.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_presc    <= '0;
            r_tick_cnt <= '0;
        end else if (i_en) begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wav_recorder.sv
// PWM audio capture: demodulates 256-tick frames into 8-bit samples written to a RAM.
module wav_recorder
    import wav_recorder_pkg::*;
#(
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE,
    parameter int unsigned ADDR_W   = 11
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic                i_pwm_in,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_ram_we,
    output logic [ADDR_W-1:0]   o_ram_a,
    output logic [SAMPLE_W-1:0] o_ram_d,
    output logic [ADDR_W:0]     o_count
);

    snd_state_e          r_state;
    logic [1:0]          r_sync;
    logic                r_busy;
    logic                r_done;
    logic                r_ram_we;
    logic [ADDR_W-1:0]   r_ram_a;
    logic [SAMPLE_W-1:0] r_ram_d;
    logic [ADDR_W:0]     r_count;
    logic [ADDR_W-1:0]   r_addr;
    logic [SAMPLE_W:0]   r_acc;

    logic                w_pwm_s;
    logic                w_capture;
    logic                w_start_ok;
    logic                w_tick;
    logic                w_frame_end;
    logic [SAMPLE_W:0]   w_acc_next;
    logic                w_last_addr;

    assign w_pwm_s     = r_sync[1];
    assign w_capture   = (r_state == StCapture);
    assign w_start_ok  = i_start && !w_capture;
    assign w_acc_next  = r_acc + {{SAMPLE_W{1'b0}}, w_pwm_s};
    assign w_last_addr = (r_addr == '1);

    wav_recorder_pwm_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clear     (w_start_ok),
        .i_en        (w_capture),
        .o_tick      (w_tick),
        .o_frame_end (w_frame_end)
    );

    // Two-flop synchroniser for the asynchronous PWM input.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], i_pwm_in};
        end
    end

    // Capture FSM with registered outputs; the RAM write lands the cycle after frame end.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= StIdle;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ram_we <= 1'b0;
            r_ram_a  <= '0;
            r_ram_d  <= '0;
            r_count  <= '0;
            r_addr   <= '0;
            r_acc    <= '0;
        end else begin
            r_ram_we <= 1'b0;
            unique case (r_state)
                StIdle, StDone: begin
                    if (i_start) begin
                        r_state <= StCapture;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_acc   <= '0;
                        r_addr  <= '0;
                        r_count <= '0;
                    end
                end
                StCapture: begin
                    if (w_frame_end) begin
                        // Completed frame is written even if stop arrives on this tick.
                        r_ram_we <= 1'b1;
                        r_ram_a  <= r_addr;
                        r_ram_d  <= sat_sample(w_acc_next);
                        r_count  <= r_count + 1'b1;
                        r_acc    <= '0;
                        r_addr   <= r_addr + 1'b1;
                        if (w_last_addr || i_stop) begin
                            r_state <= StDone;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        if (w_tick) begin
                            r_acc <= w_acc_next;
                        end
                        // Partial frame is dropped on abort.
                        if (i_stop) begin
                            r_state <= StDone;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_ram_we = r_ram_we;
    assign o_ram_a  = r_ram_a;
    assign o_ram_d  = r_ram_d;
    assign o_count  = r_count;

endmodule

// File: doc/wav_recorder.md
Name: wav_recorder

Overview:
- Capture-side counterpart of the PWM sample player: demodulates a 1-bit PWM audio stream into 8-bit samples and writes them sequentially into a sample RAM.
- Each sample frame is 256 ticks long, and one tick occurs every PRESCALE clocks. The sample value is the number of ticks in the frame on which the input was high.
- A frame of value v generated by the player (high while v > counter) is recovered as exactly v.
- Sits beside the sound ROM/RAM in the sound test top and feeds record/playback loopback tests.

Parameters:
- PRESCALE, 25, clocks per PWM tick (8 kHz x 256 at the system clock); legal range >= 2.
- ADDR_W, 11, sample RAM address width; capture length is 2^ADDR_W samples.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse that begins a capture; ignored while busy
- stop  input  1  single-cycle pulse that aborts a capture; the partial frame is discarded
- pwm_in  input  1  asynchronous 1-bit PWM audio input
- busy  output  1  high while armed or capturing
- done  output  1  sticky; set when a capture ends, cleared by the next accepted start or by reset
- ram_we  output  1  one-cycle write strobe
- ram_a  output  ADDR_W  write address
- ram_d  output  8  write data (demodulated sample)
- count  output  ADDR_W+1  number of samples written in the current/last capture

Behaviour:
- Reset: state IDLE; busy, done, ram_we, ram_a, ram_d, count, prescaler, tick counter, accumulator and synchroniser all 0. Reset wins over every other input in the same cycle.
- Input path: pwm_in passes through a 2-flop synchroniser (pwm_s). It contributes 2 clocks of latency and is never bypassed.
- FSM states: IDLE, CAPTURE, DONE.
- IDLE, start=1: go to CAPTURE on the next clock. Clear prescaler, tick counter (8-bit), accumulator (9-bit), address and count; clear done; set busy.
- CAPTURE:
  - The prescaler counts 0..PRESCALE-1 and wraps. A tick fires in the cycle it equals PRESCALE-1.
  - On each tick: accumulator += pwm_s, then tick counter += 1 (wrapping 255 -> 0).
  - On the tick where the tick counter == 255 (frame end):
    - Sample = accumulator including this tick's pwm_s, saturated to 255 (a value of 256 is only possible from a non-player source).
    - Next cycle: ram_we=1 for exactly one cycle, with ram_a=address and ram_d=sample. count increments in that same cycle.
    - Accumulator is cleared for the next frame with no lost tick.
    - address += 1. If the written address was 2^ADDR_W-1, go to DONE instead: busy=0, done=1, and address wraps to 0.
- stop in CAPTURE: go to DONE the next clock. No write for the partial frame; count keeps completed samples only. If stop coincides with a frame-end tick, the completed sample is still written (ram_we in the following cycle) and then the FSM enters DONE.
- DONE: done=1 and busy=0. Outputs hold. start=1 behaves as in IDLE (done clears, a new capture begins). DONE -> IDLE occurs only through that path or through reset.
- start while busy: ignored. stop while not busy: ignored.
- ram_a and ram_d hold their last values when ram_we=0. ram_we never asserts outside CAPTURE except the single post-frame-end write cycle.
- Throughput: one RAM write per 256*PRESCALE clocks. Frame 0 starts at the first tick after start is accepted; phase alignment to the source is the system's responsibility.

Decomposition:
- Shared sound package holds the constants FRAME_TICKS=256, SAMPLE_W=8 and DEFAULT_PRESCALE=25, plus the FSM state encoding (IDLE/CAPTURE/DONE). The player uses the same package.
- One natural sub-module: pwm_tick_gen (prescaler plus 8-bit tick counter, with tick and frame_end outputs), reusable by the player.
- The synchroniser is inline.

Test Plan (PRESCALE=2, ADDR_W=3 unless stated):
- Reset then start; pwm_in driven high on the first v ticks of each frame for v = 0, 1, 128, 255, 7, 200, 64, 3 -> eight writes at ram_a 0..7 with exactly those ram_d values, one write every 512 clocks, then done=1, busy=0, count=8.
- pwm_in held constant 1 for a full frame -> ram_d=255 (saturated), no wrap to 0; constant 0 -> ram_d=0.
- stop asserted mid-frame 3 -> writes only at addresses 0..2, count=3, done=1, no ram_we afterwards. Repeat with stop on the frame-end tick of frame 3 -> write at address 3 occurs, count=4.
- start pulses during CAPTURE and stop pulses in IDLE -> no state change, no extra writes. start in DONE -> done clears, count=0, writes restart at address 0.
- Reset asserted mid-capture, simultaneously with a frame-end tick -> no ram_we and all outputs 0 on the next cycle. start 10 cycles later captures normally from address 0.
- Loopback with default parameters: the existing wav player driven from a known ROM image feeds pwm_in, with frame phase aligned -> the first 16 recorded samples equal the ROM bytes exactly.
